// File: rtl/vend_ctrl_fsm.sv
// vend_ctrl_fsm: control FSM for a single-product vending machine.
// It accumulates coin credit and dispenses one product when a confirm press
// arrives with enough credit. It then returns change, or refunds all credit
// on cancel.
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high
//   coin[2:0]   - coin code level: 001=1, 010=5, 100=10; other codes ignored
//   press       - purchase confirm button (edge detected)
//   cancel_flag - refund request (level)
//   timeout     - end of dispense / change-out (level)
//   run_ind     - machine running
//   hold_ind    - transaction in progress
//   drinktk_ind - take-product indicator
//   charge_ind  - change/refund-out indicator
//   state[1:0]  - current state code
module vend_ctrl_fsm #(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] coin,
  input  logic       press,
  input  logic       cancel_flag,
  input  logic       timeout,
  output logic       run_ind,
  output logic       hold_ind,
  output logic       drinktk_ind,
  output logic       charge_ind,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COIN     = 2'b01,
    DISPENSE = 2'b10,
    CHANGE   = 2'b11
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CRED_MAX = {CREDIT_W{1'b1}};
  // A wide sum keeps a 10-unit coin representable even for narrow CREDIT_W.
  localparam int SUM_W = CREDIT_W + 4;

  state_t              cur, nxt;
  logic [CREDIT_W-1:0] credit, credit_nxt;
  logic [2:0]          coin_q;
  logic                press_q;
  logic                run_q;

  logic [3:0]          coin_amt;
  logic                coin_evt, press_evt;
  logic [CREDIT_W-1:0] add_base;
  logic [SUM_W-1:0]    sum;
  logic [CREDIT_W-1:0] sum_sat;
  logic                can_buy;

  always_comb begin
    coin_amt = 4'd0;
    case (coin)
      3'b001:  coin_amt = 4'd1;
      3'b010:  coin_amt = 4'd5;
      3'b100:  coin_amt = 4'd10;
      default: coin_amt = 4'd0;
    endcase
  end

  // A held coin counts once. coin_q must have been all-zero in the last cycle.
  assign coin_evt  = (coin_amt != 4'd0) && (coin_q == 3'b000);
  assign press_evt = press && !press_q;
  // The affordability test uses credit from before this cycle's coin.
  assign can_buy   = credit >= PRICE_C;

  // On a purchase, the coin added in the same cycle goes onto the remainder.
  assign add_base = (cur == COIN && !cancel_flag && press_evt && can_buy)
                    ? credit - PRICE_C : credit;
  assign sum      = SUM_W'(add_base) + SUM_W'(coin_amt);
  assign sum_sat  = (sum > SUM_W'(CRED_MAX)) ? CRED_MAX : sum[CREDIT_W-1:0];

  always_comb begin
    nxt        = cur;
    credit_nxt = credit;
    case (cur)
      IDLE: begin
        if (coin_evt) begin
          credit_nxt = sum_sat;
          nxt        = COIN;
        end
      end
      COIN: begin
        if (coin_evt) credit_nxt = sum_sat;
        if (cancel_flag)                nxt = CHANGE;
        else if (press_evt && can_buy) begin
          nxt        = DISPENSE;
          credit_nxt = sum_sat;
        end
      end
      DISPENSE: begin
        if (timeout) nxt = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (timeout) begin
          credit_nxt = '0;
          nxt        = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= IDLE;
      credit  <= '0;
      coin_q  <= 3'b000;
      press_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      cur     <= nxt;
      credit  <= credit_nxt;
      coin_q  <= coin;
      press_q <= press;
      run_q   <= 1'b1;
    end
  end

  // Moore outputs, decoded only from registered state.
  assign run_ind     = run_q;
  assign hold_ind    = (cur != IDLE);
  assign drinktk_ind = (cur == DISPENSE);
  assign charge_ind  = (cur == CHANGE);
  assign state       = cur;

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Directed testbench for vend_ctrl_fsm. Inputs are driven 1 ns after each
// rising edge. Outputs are packed as {run,hold,drinktk,charge,state[1:0]}
// and checked 1 ns after the edge that should have produced them.
module tb_vend_ctrl_fsm;
  logic       clk = 1'b0;
  logic       reset, press, cancel_flag, timeout;
  logic [2:0] coin;
  logic       run_ind, hold_ind, drinktk_ind, charge_ind;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] O_RST  = 6'b000000;
  localparam logic [5:0] O_IDLE = 6'b100000;
  localparam logic [5:0] O_COIN = 6'b110001;
  localparam logic [5:0] O_DISP = 6'b111010;
  localparam logic [5:0] O_CHG  = 6'b110111;

  vend_ctrl_fsm #(.PRICE(5), .CREDIT_W(8)) dut (
    .clk(clk), .reset(reset), .coin(coin), .press(press),
    .cancel_flag(cancel_flag), .timeout(timeout),
    .run_ind(run_ind), .hold_ind(hold_ind), .drinktk_ind(drinktk_ind),
    .charge_ind(charge_ind), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {run_ind, hold_ind, drinktk_ind, charge_ind, state};
  endfunction

  initial begin
    reset = 1'b1; coin = 3'b000; press = 1'b0; cancel_flag = 1'b0; timeout = 1'b0;
    repeat (3) step();
    chk("reset", outs(), O_RST);
    reset = 1'b0; step();
    chk("run_after_reset", outs(), O_IDLE);
    timeout = 1'b1; press = 1'b1; cancel_flag = 1'b1; step();
    chk("idle_ignores_ctrl", outs(), O_IDLE);
    timeout = 1'b0; press = 1'b0; cancel_flag = 1'b0; step();

    // Coin 5 held for two clocks counts once. The exact price then dispenses
    // and leaves no change.
    coin = 3'b010; step();
    chk("coin5_to_coin", outs(), O_COIN);
    step();
    chk("coin5_held", outs(), O_COIN);
    coin = 3'b000; press = 1'b1; step();
    chk("press_exact_price", outs(), O_DISP);
    press = 1'b0; timeout = 1'b1; step();
    chk("disp_no_change_idle", outs(), O_IDLE);
    timeout = 1'b0; step();

    // Credit 11 -> dispense -> change of 6 -> idle.
    coin = 3'b100; step();
    chk("coin10", outs(), O_COIN);
    coin = 3'b000; step();
    coin = 3'b001; step();
    coin = 3'b000; press = 1'b1; step();
    chk("press_11", outs(), O_DISP);
    press = 1'b0; timeout = 1'b1; step();
    chk("disp_to_change", outs(), O_CHG);
    step();
    chk("change_to_idle", outs(), O_IDLE);
    timeout = 1'b0; step();

    // Press with too little credit is ignored. Cancel then refunds.
    coin = 3'b001; step();
    coin = 3'b000; press = 1'b1; step();
    chk("press_low_credit", outs(), O_COIN);
    press = 1'b0; cancel_flag = 1'b1; step();
    chk("cancel_refund", outs(), O_CHG);
    cancel_flag = 1'b0; timeout = 1'b1; step();
    chk("refund_done", outs(), O_IDLE);
    timeout = 1'b0; step();

    // Cancel beats press at credit 5.
    coin = 3'b010; step();
    coin = 3'b000; press = 1'b1; cancel_flag = 1'b1; step();
    chk("cancel_over_press", outs(), O_CHG);
    press = 1'b0; cancel_flag = 1'b0; timeout = 1'b1; step();
    chk("cancel_over_press_done", outs(), O_IDLE);
    timeout = 1'b0;

    // An invalid coin code in IDLE is ignored.
    coin = 3'b011; step();
    chk("invalid_coin", outs(), O_IDLE);
    coin = 3'b000; step();

    // A coin in DISPENSE is ignored. Zero remaining credit means timeout goes to IDLE.
    coin = 3'b010; step();
    coin = 3'b000; press = 1'b1; step();
    press = 1'b0; coin = 3'b001; step();
    chk("disp_ignores_coin", outs(), O_DISP);
    coin = 3'b000; step();
    timeout = 1'b1; step();
    chk("disp_coin_not_added", outs(), O_IDLE);
    timeout = 1'b0; step();

    // Reset during DISPENSE with credit 5 left discards the credit.
    coin = 3'b100; step();
    coin = 3'b000; press = 1'b1; step();
    chk("disp_before_reset", outs(), O_DISP);
    press = 1'b0; reset = 1'b1; step();
    chk("reset_mid_txn", outs(), O_RST);
    reset = 1'b0; step();
    chk("post_reset_idle", outs(), O_IDLE);
    coin = 3'b001; step();
    chk("restart_coin", outs(), O_COIN);
    coin = 3'b000; press = 1'b1; step();
    chk("credit_restarted_at_1", outs(), O_COIN);
    press = 1'b0; cancel_flag = 1'b1; step();
    cancel_flag = 1'b0; timeout = 1'b1; step();
    chk("final_idle", outs(), O_IDLE);
    timeout = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_ctrl_fsm.md
Name: vend_ctrl_fsm

Overview:
Control state machine for a single-product vending machine.
- Accumulates coin credit and dispenses one product on a confirm press when credit covers the price.
- Returns change, or refunds all credit on cancel.
- Drives four panel indicators plus a 2-bit state code for the display/actuator logic.
- Dispense and change-out completion are signalled by an external timeout pulse.

Parameters:
PRICE, 5, product price in credit units (1..2^CREDIT_W-1)
CREDIT_W, 8, width of internal credit accumulator

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
coin  in  3  coin code, level; 3'b001=1 unit, 3'b010=5 units, 3'b100=10 units; any other nonzero code is invalid and ignored
press  in  1  purchase confirm button, level
cancel_flag  in  1  cancel/refund request, level
timeout  in  1  end-of-dispense / end-of-change-out indication, level, sampled each clock
run_ind  out  1  machine running indicator
hold_ind  out  1  machine occupied (transaction in progress)
drinktk_ind  out  1  take-product indicator
charge_ind  out  1  change/refund-out indicator
state  out  2  current state code

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset clears state to IDLE, credit to 0, and edge-detect registers to 0. Outputs during and after reset: run_ind=0, hold_ind=0, drinktk_ind=0, charge_ind=0, state=2'b00.
- run_ind is a register: 0 while reset=1, 1 from the first clock edge with reset=0.
- Edge detection uses registered copies coin_q and press_q.
  - Coin event: coin is a valid code and coin_q==3'b000. A held coin counts once.
  - Press event: press=1 and press_q=0.
  - cancel_flag and timeout are level-sensitive.
- States (state output = encoding):
  - IDLE 2'b00: no credit. A coin event adds its value to credit and moves to COIN. Press, cancel and timeout are ignored.
  - COIN 2'b01: credit>0. Each coin event adds its value.
    - cancel_flag=1 -> CHANGE, credit kept for refund.
    - Else a press event with credit>=PRICE -> DISPENSE, credit <= credit-PRICE (a coin event in the same cycle is also added).
    - A press event with credit<PRICE is ignored.
  - DISPENSE 2'b10: product being released; coins, press and cancel are ignored. On timeout=1 -> CHANGE if credit>0, else IDLE.
  - CHANGE 2'b11: credit being returned; coins, press and cancel are ignored. On timeout=1, credit <= 0 and -> IDLE.
- Cancel has priority over press in COIN.
- Press evaluates the credit value before the same-cycle coin addition.
- Credit addition saturates at 2^CREDIT_W-1.
- Outputs are Moore, decoded from the state register, so they change one clock after the causing input edge:
  - hold_ind=1 in COIN, DISPENSE and CHANGE.
  - drinktk_ind=1 only in DISPENSE.
  - charge_ind=1 only in CHANGE.
- Reset mid-transaction: credit is discarded and the block returns to IDLE on that edge.
- Latency: coin, press, cancel or timeout sampled at edge N -> new state visible after edge N.

Test Plan:
- Reset: reset=1 for 3 clocks -> all outputs 0, state=00. Release reset -> run_ind=1 after the next edge, state stays 00.
- Coin 3'b010 for 2 clocks -> state=01 and hold_ind=1 one clock later; credit 5, counted once. Press pulse -> state=10, drinktk_ind=1. timeout for 1 clock -> state=00, all indicators 0 except run_ind.
- Coins 3'b100 then 3'b001 (credit 11), press -> DISPENSE. timeout -> state=11, charge_ind=1 (change 6). timeout again -> state=00.
- Coin 3'b001 then press -> stays 01 (1<5). cancel_flag=1 -> state=11, charge_ind=1. timeout -> 00.
- In COIN with credit 5, press and cancel_flag in the same cycle -> CHANGE, not DISPENSE. Invalid coin 3'b011 in IDLE -> stays 00.
- In DISPENSE, assert reset=1 for one edge -> state=00, all outputs 0. Subsequent coin 3'b001 restarts from credit 1.
